pc_redirect_unit: RTL and testbench



---
 rtl/pc_redirect_pkg.sv | 24 ++
 rtl/ctrl_target_calc.sv | 73 +++++++
 rtl/pc_redirect_unit.sv | 198 +++++++++++++++++++
 tb/tb_pc_redirect_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// Shared defaults and enumerations for the next-PC redirect unit.
package pc_redirect_pkg;

  // Word-alignment shift applied to branch offsets and jump targets.
  localparam int unsigned PC_SHIFT_DEFAULT = 2;

  // Fetch PC loaded on reset.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Source of the PC loaded on the next edge.
  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_JR     = 2'd3
  } redirect_src_t;

  // IDLE: no redirect buffered. HELD: one redirect waits for the stall to drop.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_target_calc.sv
// Combinational target calculator for resolved control instructions.
// Produces the branch, jump and jump-register targets and the
// priority-selected one (jr > jump > branch).
// Optional feature macro: PC_ALIGN_CHECK_EN (forces JR targets to word
// alignment and flags a misaligned register value).
module ctrl_target_calc
  import pc_redirect_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TARGET_W = 26,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned SHIFT    = PC_SHIFT_DEFAULT
) (
  input  logic [ADDR_W-1:0]   base_pc,
  input  logic                branch_taken,
  input  logic [IMM_W-1:0]    imm,
  input  logic                jump,
  input  logic [TARGET_W-1:0] target,
  input  logic                jr,
  input  logic [ADDR_W-1:0]   rs_val,
  output logic                request,
  output logic [ADDR_W-1:0]   sel_target,
  output redirect_src_t       sel_src
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                jr_misalign
`endif
);

  // Constant +4 built from sized pieces so it tracks ADDR_W.
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  logic [ADDR_W-1:0] link_s;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] branch_target_s;
  logic [ADDR_W-1:0] jump_target_s;
  logic [ADDR_W-1:0] jr_target_s;

  // Candidate targets, all arithmetic modulo 2^ADDR_W.
  always_comb begin
    link_s          = base_pc + PC_STEP;
    offset_s        = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << SHIFT;
    branch_target_s = link_s + offset_s;
    jump_target_s   = {link_s[ADDR_W-1:TARGET_W+SHIFT], target, {SHIFT{1'b0}}};
`ifdef PC_ALIGN_CHECK_EN
    jr_target_s     = {rs_val[ADDR_W-1:SHIFT], {SHIFT{1'b0}}};
    jr_misalign     = jr & (rs_val[SHIFT-1:0] != {SHIFT{1'b0}});
`else
    jr_target_s     = rs_val;
`endif
  end

  // Priority select: jr over jump over branch.
  always_comb begin
    request    = jr | jump | branch_taken;
    sel_target = {ADDR_W{1'b0}};
    sel_src    = SRC_SEQ;
    if (jr) begin
      sel_target = jr_target_s;
      sel_src    = SRC_JR;
    end else if (jump) begin
      sel_target = jump_target_s;
      sel_src    = SRC_JUMP;
    end else if (branch_taken) begin
      sel_target = branch_target_s;
      sel_src    = SRC_BRANCH;
    end else begin
      sel_target = {ADDR_W{1'b0}};
      sel_src    = SRC_SEQ;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Next-PC generator: holds the fetch PC, applies resolved redirects and
// buffers one redirect that arrives while fetch is stalled.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds misalign_o).
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 32,
  parameter int unsigned     TARGET_W = 26,
  parameter int unsigned     IMM_W    = 16,
  parameter int unsigned     SHIFT    = PC_SHIFT_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic [ADDR_W-1:0]   base_pc_i,
  input  logic                branch_taken_i,
  input  logic [IMM_W-1:0]    imm_i,
  input  logic                jump_i,
  input  logic [TARGET_W-1:0] target_i,
  input  logic                jr_i,
  input  logic [ADDR_W-1:0]   rs_val_i,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ADDR_W-1:0]   pc_plus4_o,
  output logic                redirect_o,
  output logic                pending_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                misalign_o
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] pend_target_r;
  logic [ADDR_W-1:0] pend_target_next_s;
  logic              redirect_r;
  logic              redirect_next_s;
  logic [ADDR_W-1:0] seq_s;
  logic              request_s;
  logic [ADDR_W-1:0] sel_target_s;
  redirect_src_t     sel_src_s;
  logic              src_valid_s;
`ifdef PC_ALIGN_CHECK_EN
  logic              jr_misalign_s;
  logic              misalign_r;
  logic              misalign_next_s;
`endif

  ctrl_target_calc #(
    .ADDR_W   (ADDR_W),
    .TARGET_W (TARGET_W),
    .IMM_W    (IMM_W),
    .SHIFT    (SHIFT)
  ) u_target_calc (
    .base_pc      (base_pc_i),
    .branch_taken (branch_taken_i),
    .imm          (imm_i),
    .jump         (jump_i),
    .target       (target_i),
    .jr           (jr_i),
    .rs_val       (rs_val_i),
    .request      (request_s),
    .sel_target   (sel_target_s),
    .sel_src      (sel_src_s)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .jr_misalign  (jr_misalign_s)
`endif
  );

  // Sequential successor of the current fetch PC; wraps naturally.
  always_comb begin
    seq_s = pc_r + PC_STEP;
  end

  // A request always selects a non-sequential source; keep the select consumed.
  always_comb begin
    case (sel_src_s)
      SRC_BRANCH, SRC_JUMP, SRC_JR: src_valid_s = 1'b1;
      SRC_SEQ:                      src_valid_s = 1'b0;
      default:                      src_valid_s = 1'b0;
    endcase
  end

  // State register for the redirect buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: a stalled request parks in HELD until the stall releases.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (stall_i && request_s) begin
          state_next_s = HELD;
        end else begin
          state_next_s = IDLE;
        end
      end
      HELD: begin
        if (stall_i) begin
          state_next_s = HELD;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Next register values for PC, buffered target and the pulse outputs.
  always_comb begin
    pc_next_s          = pc_r;
    pend_target_next_s = pend_target_r;
    redirect_next_s    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_next_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!stall_i) begin
          if (request_s && src_valid_s) begin
            pc_next_s       = sel_target_s;
            redirect_next_s = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            misalign_next_s = jr_misalign_s;
`endif
          end else begin
            pc_next_s       = seq_s;
          end
        end else begin
          // Younger requests during HELD are squashed, so only IDLE captures.
          if (request_s) begin
            pend_target_next_s = sel_target_s;
`ifdef PC_ALIGN_CHECK_EN
            misalign_next_s    = jr_misalign_s;
`endif
          end else begin
            pend_target_next_s = pend_target_r;
          end
        end
      end
      HELD: begin
        if (!stall_i) begin
          pc_next_s       = pend_target_r;
          redirect_next_s = 1'b1;
        end else begin
          pc_next_s       = pc_r;
        end
      end
      default: begin
        pc_next_s       = pc_r;
        redirect_next_s = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset also drops any buffered redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      pend_target_r <= {ADDR_W{1'b0}};
      redirect_r    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_r    <= 1'b0;
`endif
    end else begin
      pc_r          <= pc_next_s;
      pend_target_r <= pend_target_next_s;
      redirect_r    <= redirect_next_s;
`ifdef PC_ALIGN_CHECK_EN
      misalign_r    <= misalign_next_s;
`endif
    end
  end

  // Output drive from registered state.
  always_comb begin
    pc_o       = pc_r;
    pc_plus4_o = seq_s;
    redirect_o = redirect_r;
    pending_o  = (state_r == HELD);
`ifdef PC_ALIGN_CHECK_EN
    misalign_o = misalign_r;
`endif
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expectations.
// Optional feature macro: PC_ALIGN_CHECK_EN (exercises misalign_o).
module tb_pc_redirect_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic [31:0] base_pc_i;
  logic        branch_taken_i;
  logic [15:0] imm_i;
  logic        jump_i;
  logic [25:0] target_i;
  logic        jr_i;
  logic [31:0] rs_val_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_o;
  logic        pending_o;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks;
  int errors;

  pc_redirect_unit #(
    .ADDR_W   (32),
    .TARGET_W (26),
    .IMM_W    (16),
    .SHIFT    (2),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .base_pc_i      (base_pc_i),
    .branch_taken_i (branch_taken_i),
    .imm_i          (imm_i),
    .jump_i         (jump_i),
    .target_i       (target_i),
    .jr_i           (jr_i),
    .rs_val_i       (rs_val_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .redirect_o     (redirect_o),
    .pending_o      (pending_o)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    branch_taken_i = 1'b0;
    jump_i         = 1'b0;
    jr_i           = 1'b0;
    base_pc_i      = 32'h0;
    imm_i          = 16'h0;
    target_i       = 26'h0;
    rs_val_i       = 32'h0;
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    stall_i = 1'b0;
    clear_req();
    #2;
    check_value("rst_pc", pc_o, 32'h0040_0000);
    check_value("rst_redirect", {31'h0, redirect_o}, 32'h0);
    check_value("rst_pending", {31'h0, pending_o}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Free-running sequential fetch.
    step(); check_value("seq1", pc_o, 32'h0040_0004);
    check_value("seq1_redir", {31'h0, redirect_o}, 32'h0);
    step(); check_value("seq2", pc_o, 32'h0040_0008);
    step(); check_value("seq3", pc_o, 32'h0040_000C);
    check_value("seq3_plus4", pc_plus4_o, 32'h0040_0010);
    check_value("seq3_redir", {31'h0, redirect_o}, 32'h0);

    // Backward branch: 0x400014 - 16.
    branch_taken_i = 1'b1; base_pc_i = 32'h0040_0010; imm_i = 16'hFFFC;
    step(); check_value("branch_neg", pc_o, 32'h0040_0004);
    check_value("branch_redir", {31'h0, redirect_o}, 32'h1);
    clear_req();
    step(); check_value("after_branch", pc_o, 32'h0040_0008);
    check_value("redir_pulse_end", {31'h0, redirect_o}, 32'h0);

    // Forward branch: 0x104 + 12.
    branch_taken_i = 1'b1; base_pc_i = 32'h0000_0100; imm_i = 16'h0003;
    step(); check_value("branch_pos", pc_o, 32'h0000_0110);
    clear_req();

    // Jump keeps the upper link bits.
    jump_i = 1'b1; base_pc_i = 32'h3000_0000; target_i = 26'h010_0000;
    step(); check_value("jump", pc_o, 32'h3040_0000);
    check_value("jump_redir", {31'h0, redirect_o}, 32'h1);
    clear_req();
    step(); check_value("after_jump", pc_o, 32'h3040_0004);

    // Jump beats branch.
    jump_i = 1'b1; branch_taken_i = 1'b1; base_pc_i = 32'h1000_0000;
    target_i = 26'h000_0004; imm_i = 16'h0100;
    step(); check_value("jump_over_branch", pc_o, 32'h1000_0010);
    clear_req();
    step(); check_value("seq_after_prio", pc_o, 32'h1000_0014);

    // Stalled JR is buffered; later requests are squashed.
    stall_i = 1'b1; jr_i = 1'b1; rs_val_i = 32'h0000_1230;
    step(); check_value("stall1_pc", pc_o, 32'h1000_0014);
    check_value("stall1_pending", {31'h0, pending_o}, 32'h1);
    check_value("stall1_redir", {31'h0, redirect_o}, 32'h0);
    clear_req(); jump_i = 1'b1; target_i = 26'h3FF_FFFF;
    step(); check_value("stall2_pc", pc_o, 32'h1000_0014);
    check_value("stall2_pending", {31'h0, pending_o}, 32'h1);
    clear_req();
    step(); check_value("stall3_pc", pc_o, 32'h1000_0014);
    stall_i = 1'b0; branch_taken_i = 1'b1; base_pc_i = 32'h0000_8000; imm_i = 16'h0010;
    step(); check_value("release_pc", pc_o, 32'h0000_1230);
    check_value("release_redir", {31'h0, redirect_o}, 32'h1);
    check_value("release_pending", {31'h0, pending_o}, 32'h0);
    clear_req();
    step(); check_value("post_release", pc_o, 32'h0000_1234);
    check_value("post_release_redir", {31'h0, redirect_o}, 32'h0);

    // JR beats jump.
    jr_i = 1'b1; rs_val_i = 32'h0000_2000; jump_i = 1'b1; target_i = 26'h000_0001;
    step(); check_value("jr_over_jump", pc_o, 32'h0000_2000);
    clear_req();

    // Asynchronous reset while HELD discards the buffered target.
    stall_i = 1'b1; jr_i = 1'b1; rs_val_i = 32'h0000_5000;
    step(); check_value("held_pending", {31'h0, pending_o}, 32'h1);
    #2; reset = 1'b1; #1;
    check_value("async_rst_pc", pc_o, 32'h0040_0000);
    check_value("async_rst_pending", {31'h0, pending_o}, 32'h0);
    #1; reset = 1'b0; stall_i = 1'b0; clear_req();
    step(); check_value("rst_discard", pc_o, 32'h0040_0004);
    check_value("rst_discard_redir", {31'h0, redirect_o}, 32'h0);

    // Wrap-around of the sequential path.
    jr_i = 1'b1; rs_val_i = 32'hFFFF_FFFC;
    step(); check_value("top_pc", pc_o, 32'hFFFF_FFFC);
    check_value("top_plus4", pc_plus4_o, 32'h0000_0000);
    clear_req();
    step(); check_value("wrap", pc_o, 32'h0000_0000);

`ifdef PC_ALIGN_CHECK_EN
    jr_i = 1'b1; rs_val_i = 32'h0000_1002;
    step(); check_value("misalign_pc", pc_o, 32'h0000_1000);
    check_value("misalign_hi", {31'h0, misalign_o}, 32'h1);
    clear_req();
    step(); check_value("misalign_lo", {31'h0, misalign_o}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound in case the stimulus thread stalls.
  initial begin
    #20000;
    $display("FAIL timeout got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
